// File: rtl/fp_accumulate_ctrl_pkg.sv
// Shared floating-point types for the accumulator controller.
// fp_t is an IEEE-754 binary64 layout (sign, biased exponent, significand).
// FP_EXP_MAX is the all-ones exponent (infinity / NaN encodings).
package fp_accumulate_ctrl_pkg;

  localparam int unsigned FP_EXP_W = 11;
  localparam int unsigned FP_SIG_W = 52;
  localparam int unsigned FP_W     = 1 + FP_EXP_W + FP_SIG_W;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_SIG_W-1:0] sig;
  } fp_t;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;

  // True when the value has saturated the exponent field.
  function automatic logic fp_exp_is_max(input fp_t x);
    return x.exp == FP_EXP_MAX;
  endfunction

endpackage

// File: rtl/fp_accumulate_ctrl_if.sv
// Term-in / total-out stream plus adder operand/result wiring.
// master: producer of terms, adder result and consumer ready (the parent / bench).
// slave : the accumulator controller itself.
interface fp_accumulate_ctrl_if #(
  parameter int unsigned COUNT_W = 8
);
  import fp_accumulate_ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  fp_t                in_data;
  logic               in_last;
  fp_t                add_a;
  fp_t                add_b;
  fp_t                add_result;
  logic               out_valid;
  logic               out_ready;
  fp_t                out_data;
  logic [COUNT_W-1:0] out_count;
  logic               out_ovf;

  modport master (
    output in_valid, in_data, in_last, add_result, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, add_result, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/fp_accumulate_ctrl.sv
// Accumulator controller around a combinational FP adder: sums a frame of
// fp_t terms and emits one total per frame with its term count.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - fp_accumulate_ctrl_if.slave: term stream in, adder a/b out,
//          adder result in, total/count/ovf stream out
// Parameter COUNT_W: term counter width; a frame is force-closed at 2**COUNT_W-1 terms.
// Macro FP_ACC_OVF_EN: when defined, out_ovf reports a sticky exponent-overflow
// flag for the frame; when undefined out_ovf is tied low.
module fp_accumulate_ctrl
  import fp_accumulate_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  fp_accumulate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_t             state_q, state_d;
  fp_t                acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               in_ready_q;
  logic               out_valid_q;
  fp_t                out_data_q;
  logic [COUNT_W-1:0] out_count_q;
  logic               accept_c;

`ifdef FP_ACC_OVF_EN
  logic ovf_q, ovf_d;
  logic out_ovf_q;
`endif

  assign accept_c = bus.in_valid & in_ready_q;

  // Next-state: first term bypasses the adder, later terms take its result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
`ifdef FP_ACC_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_d   = bus.in_data;
          count_d = COUNT_ONE;
          state_d = (bus.in_last || COUNT_ONE == COUNT_MAX) ? DONE : ACCUM;
`ifdef FP_ACC_OVF_EN
          ovf_d   = fp_exp_is_max(bus.in_data);
`endif
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d   = bus.add_result;
          count_d = count_q + COUNT_ONE;
          // Forced close keeps the counter from ever wrapping.
          state_d = (bus.in_last || count_d == COUNT_MAX) ? DONE : ACCUM;
`ifdef FP_ACC_OVF_EN
          ovf_d   = ovf_q | fp_exp_is_max(bus.add_result);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef FP_ACC_OVF_EN
      ovf_q       <= 1'b0;
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
`ifdef FP_ACC_OVF_EN
      ovf_q       <= ovf_d;
`endif
      if (state_d == DONE) begin
        out_data_q  <= acc_d;
        out_count_q <= count_d;
`ifdef FP_ACC_OVF_EN
        out_ovf_q   <= ovf_d;
`endif
      end else begin
        out_data_q  <= '0;
        out_count_q <= '0;
`ifdef FP_ACC_OVF_EN
        out_ovf_q   <= 1'b0;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.add_a     = acc_q;
  assign bus.add_b     = bus.in_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
`ifdef FP_ACC_OVF_EN
  assign bus.out_ovf   = out_ovf_q;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accumulate_ctrl.sv
// Bench for fp_accumulate_ctrl: two instances (COUNT_W=8 and COUNT_W=2), each
// beside a behavioural double-precision adder. Expected totals come from a
// frame-level model that sums decoded reals in acceptance order.
module tb_fp_accumulate_ctrl;
  import fp_accumulate_ctrl_pkg::*;

`ifdef FP_ACC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp_accumulate_ctrl_if #(.COUNT_W(8)) bus8 ();
  fp_accumulate_ctrl_if #(.COUNT_W(2)) bus2 ();

  fp_accumulate_ctrl #(.COUNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  fp_accumulate_ctrl #(.COUNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic fp_t fp_add(input fp_t a, input fp_t b);
    return fp_t'($realtobits($bitstoreal(a) + $bitstoreal(b)));
  endfunction

  assign bus8.add_result = fp_add(bus8.add_a, bus8.add_b);
  assign bus2.add_result = fp_add(bus2.add_a, bus2.add_b);

  function automatic bit exp_max(input real v);
    logic [63:0] b;
    b = $realtobits(v);
    return b[62:52] == 11'h7FF;
  endfunction

  // Frame model for the COUNT_W=8 instance.
  real run_sum = 0.0;
  int  run_cnt = 0;
  bit  run_ovf = 1'b0;

  // Monitor for the COUNT_W=2 instance: one sample per output handshake.
  logic [63:0] mon2_data[$];
  int          mon2_cnt[$];
  always @(negedge clk) begin
    if (bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
      mon2_data.push_back(bus2.out_data);
      mon2_cnt.push_back(int'(bus2.out_count));
    end
  end

  task automatic push8(input real v, input bit last);
    bus8.in_valid = 1'b1;
    bus8.in_data  = fp_t'($realtobits(v));
    bus8.in_last  = last;
    for (int i = 0; i < 50; i++) begin
      if (bus8.in_ready === 1'b1) begin
        if (run_cnt != 0) begin
          checks++;
          if (bus8.add_a !== fp_t'($realtobits(run_sum))) begin
            failures++;
            $display("FAIL add_a got=%h want=%h", bus8.add_a, $realtobits(run_sum));
          end
        end
        @(posedge clk); #1;
        if (run_cnt == 0) begin
          run_sum = v;
          run_ovf = exp_max(v);
        end else begin
          run_sum = run_sum + v;
          run_ovf = run_ovf | exp_max(run_sum);
        end
        run_cnt++;
        bus8.in_valid = 1'b0;
        bus8.in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL push_timeout got=in_ready_low want=accept");
    bus8.in_valid = 1'b0;
  endtask

  // Wait for the total, compare against the model, hold for 'stall' cycles, then take it.
  task automatic expect_total(input string name, input int max_wait, input int stall);
    logic [63:0] exp_data;
    bit          found;
    exp_data = $realtobits(run_sum);
    found = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bus8.out_valid === 1'b1) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s_latency got=out_valid_low want=high within %0d", name, max_wait);
    end else begin
      checks++;
      if (bus8.out_data !== fp_t'(exp_data)) begin
        failures++;
        $display("FAIL %s_data got=%h want=%h", name, bus8.out_data, exp_data);
      end
      checks++;
      if (bus8.out_count !== 8'(run_cnt)) begin
        failures++;
        $display("FAIL %s_count got=%0d want=%0d", name, bus8.out_count, run_cnt);
      end
      checks++;
      if (bus8.out_ovf !== (OVF_ON & run_ovf)) begin
        failures++;
        $display("FAIL %s_ovf got=%b want=%b", name, bus8.out_ovf, OVF_ON & run_ovf);
      end
      checks++;
      if (bus8.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_in_ready_done got=%b want=0", name, bus8.in_ready);
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.out_data !== fp_t'(exp_data) ||
            bus8.out_count !== 8'(run_cnt) || bus8.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s_hold got=v%b d=%h c=%0d r=%b want=v1 d=%h c=%0d r=0", name,
                   bus8.out_valid, bus8.out_data, bus8.out_count, bus8.in_ready,
                   exp_data, run_cnt);
        end
      end
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_release got=v%b r=%b want=v0 r1", name, bus8.out_valid, bus8.in_ready);
      end
    end
    run_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.out_data !== '0 ||
        bus8.out_count !== 8'd0 || bus8.out_ovf !== 1'b0 || bus2.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got=r%b v%b d=%h c=%0d o=%b want=r1 v0 d=0 c=0 o=0",
               bus8.in_ready, bus8.out_valid, bus8.out_data, bus8.out_count, bus8.out_ovf);
    end
  endtask

  task automatic test_three_terms();
    push8(1.0, 1'b0);
    push8(2.0, 1'b0);
    push8(0.5, 1'b1);
    expect_total("three", 1, 0);
  endtask

  task automatic test_single();
    push8(-1.5, 1'b1);
    expect_total("single", 1, 0);
  endtask

  task automatic test_hold();
    push8(4.0, 1'b0);
    push8(-4.0, 1'b0 | 1'b1);
    // Stray term while DONE must be ignored.
    bus8.in_valid = 1'b1;
    bus8.in_data  = fp_t'($realtobits(99.0));
    bus8.in_last  = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_data !== fp_t'(64'd0) ||
          bus8.out_count !== 8'd2 || bus8.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall got=v%b d=%h c=%0d r=%b want=v1 d=0 c=2 r=0",
                 bus8.out_valid, bus8.out_data, bus8.out_count, bus8.in_ready);
      end
    end
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    run_cnt = 0;
    @(negedge clk);
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_resume got=r%b v%b want=r1 v0", bus8.in_ready, bus8.out_valid);
    end
    push8(5.0, 1'b1);
    expect_total("after_hold", 1, 0);
  endtask

  task automatic test_force_close();
    real         terms[6];
    bit          lasts[6];
    logic [63:0] exp_d[$];
    int          exp_c[$];
    real         s;
    int          c;
    terms = '{1.0, 1.0, 1.0, 1.0, 1.0, 0.5};
    lasts = '{0, 0, 0, 0, 0, 1};
    // Model: frame closes on in_last or at 2**2-1 = 3 terms.
    s = 0.0; c = 0;
    for (int i = 0; i < 6; i++) begin
      s = (c == 0) ? terms[i] : s + terms[i];
      c++;
      if (lasts[i] || c == 3) begin
        exp_d.push_back($realtobits(s));
        exp_c.push_back(c);
        c = 0;
      end
    end
    mon2_data.delete();
    mon2_cnt.delete();
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = fp_t'($realtobits(terms[i]));
      bus2.in_last  = lasts[i];
      for (int w = 0; w < 20; w++) begin
        if (bus2.in_ready === 1'b1) break;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    bus2.in_last  = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (mon2_data.size() != exp_d.size()) begin
      failures++;
      $display("FAIL force_frames got=%0d want=%0d", mon2_data.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        checks++;
        if (mon2_data[i] !== exp_d[i] || mon2_cnt[i] != exp_c[i]) begin
          failures++;
          $display("FAIL force_frame%0d got=%h/%0d want=%h/%0d", i, mon2_data[i],
                   mon2_cnt[i], exp_d[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    push8(1.0, 1'b0);
    push8(1.0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL mid_reset got=v%b r=%b want=v0 r1", bus8.out_valid, bus8.in_ready);
      end
    end
    push8(2.0, 1'b0);
    push8(1.0, 1'b1);
    expect_total("post_reset", 1, 0);
  endtask

  task automatic test_ovf();
    real big;
    big = $bitstoreal(64'h7FEF_FFFF_FFFF_FFFF);
    push8(big, 1'b0);
    push8(big, 1'b1);
    expect_total("ovf_set", 1, 2);
    push8(1.0, 1'b1);
    expect_total("ovf_clear", 1, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int f = 0; f < 12; f++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int t = 0; t < len; t++) begin
        int gap;
        real v;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
        v = real'(int'($urandom_range(0, 4000)) - 2000) / 16.0;
        push8(v, t == len - 1);
      end
      expect_total("random", 3, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0; bus2.out_ready = 1'b0;
    test_reset();
    test_three_terms();
    test_single();
    test_hold();
    test_force_close();
    test_mid_reset();
    test_ovf();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
